// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
// Sequencing FSM for the vending machine datapath. It accumulates coin credit,
// accepts a product selection, issues a dispense request over a valid/ready
// handshake, then pays change back one CHANGE_UNIT coin per handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   coin_valid, coin_value   coin-inserted strobe and its value in cents
//   sel_valid, sel_item      selection strobe and product index
//   cancel                   refund request strobe
//   vend_valid, vend_item    dispense request / product (held until vend_ready)
//   vend_ready               dispenser accepts the request
//   change_valid             one change coin offered
//   change_ready             hopper accepts the coin
//   coin_reject              1-cycle pulse: coin returned, credit unchanged
//   sel_error                1-cycle pulse: credit below the selected price
//   credit                   current credit in cents
//   busy                     high while vending or paying change
// ---------------------------------------------------------------------------
module vend_controller #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned NUM_ITEMS   = 4,
    // Item i occupies bits [i*CREDIT_W +: CREDIT_W]; item 0 (100c) is the low byte.
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd50, 8'd75, 8'd100},
    parameter int unsigned MAX_CREDIT  = 200,
    parameter int unsigned CHANGE_UNIT = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [CREDIT_W-1:0]          coin_value,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
    input  logic                         cancel,
    output logic                         vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
    input  logic                         vend_ready,
    output logic                         change_valid,
    input  logic                         change_ready,
    output logic                         coin_reject,
    output logic                         sel_error,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy
);

    localparam int unsigned ITEM_W = $clog2(NUM_ITEMS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [ITEM_W-1:0]   item_nxt;
    logic                reject_nxt;
    logic                sel_err_nxt;
    logic                vend_valid_nxt;
    logic                change_valid_nxt;
    logic                busy_nxt;

    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;

    // Price lookup and coin acceptance; the sum is one bit wider so it cannot wrap.
    assign sel_price = PRICES[sel_item*CREDIT_W +: CREDIT_W];
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
    assign coin_ok   = (coin_value != '0)
                    && ((coin_value % CREDIT_W'(CHANGE_UNIT)) == '0)
                    && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            vend_item    <= '0;
            vend_valid   <= 1'b0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            sel_error    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            vend_item    <= item_nxt;
            vend_valid   <= vend_valid_nxt;
            change_valid <= change_valid_nxt;
            coin_reject  <= reject_nxt;
            sel_error    <= sel_err_nxt;
            busy         <= busy_nxt;
        end
    end

    // Next-state and credit logic; in IDLE/COLLECT cancel beats sel_valid beats coin.
    always_comb begin
        state_nxt   = state;
        credit_nxt  = credit;
        item_nxt    = vend_item;
        reject_nxt  = 1'b0;
        sel_err_nxt = 1'b0;
        unique case (state)
            IDLE, COLLECT: begin
                if (cancel && (state == COLLECT)) begin
                    state_nxt  = CHANGE;
                    reject_nxt = coin_valid;
                end else if (sel_valid) begin
                    reject_nxt = coin_valid;
                    if ((state == COLLECT) && (credit >= sel_price)) begin
                        item_nxt   = sel_item;
                        credit_nxt = credit - sel_price;
                        state_nxt  = VEND;
                    end else begin
                        sel_err_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        state_nxt  = COLLECT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                reject_nxt = coin_valid;
                if (vend_valid && vend_ready) begin
                    state_nxt = (credit != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                reject_nxt = coin_valid;
                if (change_valid && change_ready) begin
                    credit_nxt = credit - CREDIT_W'(CHANGE_UNIT);
                    // Last coin: leave CHANGE in the same cycle credit becomes 0.
                    if (credit == CREDIT_W'(CHANGE_UNIT)) begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    // Handshake outputs follow the state being entered, so they register with it.
    // CHANGE is only ever held with nonzero credit.
    always_comb begin
        vend_valid_nxt   = (state_nxt == VEND);
        change_valid_nxt = (state_nxt == CHANGE);
        busy_nxt         = (state_nxt == VEND) || (state_nxt == CHANGE);
    end

endmodule

// File: tb/tb_vend_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_controller
// Self-checking bench for vend_controller: directed scenarios plus a random
// run compared each cycle against a transaction-level model of the machine
// (credit, pending vend, pending refund).
// ---------------------------------------------------------------------------
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       vend_ready;
    logic       change_valid;
    logic       change_ready;
    logic       coin_reject;
    logic       sel_error;
    logic [7:0] credit;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int price_tab[4] = '{100, 75, 50, 25};
    int coin_tab[9]  = '{5, 10, 25, 50, 100, 7, 0, 3, 200};

    vend_controller dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .vend_valid   (vend_valid),
        .vend_item    (vend_item),
        .vend_ready   (vend_ready),
        .change_valid (change_valid),
        .change_ready (change_ready),
        .coin_reject  (coin_reject),
        .sel_error    (sel_error),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0;
        sel_item = '0; cancel = 1'b0; vend_ready = 1'b0; change_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic insert_coin(input int v);
        coin_valid = 1'b1; coin_value = 8'(v);
        step();
        coin_valid = 1'b0;
    endtask

    task automatic select(input int it);
        sel_valid = 1'b1; sel_item = 2'(it);
        step();
        sel_valid = 1'b0;
    endtask

    // Hold change_ready high and count handshakes until change_valid drops.
    task automatic drain_change(output int hs);
        hs = 0;
        change_ready = 1'b1;
        for (int i = 0; i < 60 && change_valid; i++) begin
            hs++;
            step();
        end
        change_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({vend_valid, vend_item, change_valid, coin_reject, sel_error, credit, busy} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got vv=%0b vi=%0d cv=%0b rj=%0b se=%0b cr=%0d busy=%0b, expected all 0",
                     vend_valid, vend_item, change_valid, coin_reject, sel_error, credit, busy);
        end
    endtask

    task automatic test_exact_pay();
        apply_reset();
        insert_coin(25);
        n_checks++;
        if (credit !== 8'd25) begin n_errors++; $display("FAIL exact_first_coin: credit=%0d expected 25", credit); end
        insert_coin(25);
        insert_coin(50);
        n_checks++;
        if (credit !== 8'd100) begin n_errors++; $display("FAIL exact_credit: credit=%0d expected 100", credit); end
        select(0);
        n_checks++;
        if (vend_valid !== 1'b1 || vend_item !== 2'd0 || credit !== 8'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL exact_vend: vv=%0b vi=%0d cr=%0d busy=%0b expected 1 0 0 1", vend_valid, vend_item, credit, busy);
        end
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        step();
        n_checks++;
        if (vend_valid !== 1'b0 || change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL exact_done: vv=%0b cv=%0b cr=%0d busy=%0b expected 0 0 0 0", vend_valid, change_valid, credit, busy);
        end
    endtask

    task automatic test_overpay();
        int hs;
        apply_reset();
        insert_coin(100);
        insert_coin(25);
        select(1);
        n_checks++;
        if (vend_valid !== 1'b1 || vend_item !== 2'd1 || credit !== 8'd50) begin
            n_errors++;
            $display("FAIL overpay_vend: vv=%0b vi=%0d cr=%0d expected 1 1 50", vend_valid, vend_item, credit);
        end
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        n_checks++;
        if (vend_valid !== 1'b0 || change_valid !== 1'b1 || credit !== 8'd50) begin
            n_errors++;
            $display("FAIL overpay_change_start: vv=%0b cv=%0b cr=%0d expected 0 1 50", vend_valid, change_valid, credit);
        end
        drain_change(hs);
        n_checks++;
        if (hs != 10 || credit !== 8'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL overpay_refund: handshakes=%0d cr=%0d busy=%0b expected 10 0 0", hs, credit, busy);
        end
    endtask

    task automatic test_short_pay();
        int hs;
        apply_reset();
        insert_coin(25);
        select(0);
        n_checks++;
        if (sel_error !== 1'b1 || credit !== 8'd25 || vend_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL short_sel_error: se=%0b cr=%0d vv=%0b busy=%0b expected 1 25 0 0", sel_error, credit, vend_valid, busy);
        end
        step();
        n_checks++;
        if (sel_error !== 1'b0) begin n_errors++; $display("FAIL short_pulse_width: se=%0b expected 0", sel_error); end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        drain_change(hs);
        n_checks++;
        if (hs != 5 || credit !== 8'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL short_refund: handshakes=%0d cr=%0d busy=%0b expected 5 0 0", hs, credit, busy);
        end
    endtask

    task automatic test_rejects();
        apply_reset();
        insert_coin(7);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd0) begin
            n_errors++;
            $display("FAIL reject_odd_coin: rj=%0b cr=%0d expected 1 0", coin_reject, credit);
        end
        step();
        n_checks++;
        if (coin_reject !== 1'b0) begin n_errors++; $display("FAIL reject_pulse_width: rj=%0b expected 0", coin_reject); end
        insert_coin(100);
        insert_coin(100);
        insert_coin(5);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd200) begin
            n_errors++;
            $display("FAIL reject_ceiling: rj=%0b cr=%0d expected 1 200", coin_reject, credit);
        end
        select(3);
        insert_coin(25);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd175 || vend_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reject_in_vend: rj=%0b cr=%0d vv=%0b expected 1 175 1", coin_reject, credit, vend_valid);
        end
    endtask

    task automatic test_backpressure();
        int exp_credit;
        int cyc;
        apply_reset();
        insert_coin(100);
        select(2);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (vend_valid !== 1'b1 || vend_item !== 2'd2 || credit !== 8'd50) begin
                n_errors++;
                $display("FAIL hold_vend[%0d]: vv=%0b vi=%0d cr=%0d expected 1 2 50", i, vend_valid, vend_item, credit);
            end
            step();
        end
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        exp_credit = 50;
        cyc = 0;
        while (exp_credit > 0 && cyc < 40) begin
            change_ready = cyc[0];
            if (change_ready) exp_credit -= 5;
            step();
            cyc++;
            n_checks++;
            if (credit !== 8'(exp_credit) || change_valid !== (exp_credit > 0)) begin
                n_errors++;
                $display("FAIL toggle_change[%0d]: cr=%0d cv=%0b expected %0d %0b", cyc, credit, change_valid, exp_credit, exp_credit > 0);
            end
        end
        change_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || exp_credit != 0) begin
            n_errors++;
            $display("FAIL toggle_done: busy=%0b model credit=%0d expected 0 0", busy, exp_credit);
        end
    endtask

    task automatic test_reset_mid_change();
        apply_reset();
        insert_coin(100);
        insert_coin(5);
        select(1);
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        n_checks++;
        if (change_valid !== 1'b1 || credit !== 8'd30) begin
            n_errors++;
            $display("FAIL mid_change_setup: cv=%0b cr=%0d expected 1 30", change_valid, credit);
        end
        rst = 1'b1; change_ready = 1'b1;
        step();
        rst = 1'b0; change_ready = 1'b0;
        n_checks++;
        if ({vend_valid, vend_item, change_valid, coin_reject, sel_error, credit, busy} !== 15'd0) begin
            n_errors++;
            $display("FAIL mid_change_reset: vv=%0b vi=%0d cv=%0b rj=%0b se=%0b cr=%0d busy=%0b expected all 0",
                     vend_valid, vend_item, change_valid, coin_reject, sel_error, credit, busy);
        end
    endtask

    task automatic test_coincident();
        int hs;
        apply_reset();
        insert_coin(50);
        cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd3; coin_valid = 1'b1; coin_value = 8'd25;
        step();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0;
        n_checks++;
        if (change_valid !== 1'b1 || coin_reject !== 1'b1 || vend_valid !== 1'b0 || sel_error !== 1'b0 || credit !== 8'd50) begin
            n_errors++;
            $display("FAIL coincident_strobes: cv=%0b rj=%0b vv=%0b se=%0b cr=%0d expected 1 1 0 0 50",
                     change_valid, coin_reject, vend_valid, sel_error, credit);
        end
        drain_change(hs);
        n_checks++;
        if (hs != 10 || credit !== 8'd0) begin
            n_errors++;
            $display("FAIL coincident_refund: handshakes=%0d cr=%0d expected 10 0", hs, credit);
        end
    endtask

    // Random single-strobe traffic against a model holding credit, a pending
    // vend and a pending refund.
    task automatic test_random();
        int  m_credit;
        int  m_item;
        bit  m_vend;
        bit  m_refund;
        bit  e_rej;
        bit  e_err;
        int  r;
        int  v;
        int  it;
        apply_reset();
        m_credit = 0; m_item = 0; m_vend = 0; m_refund = 0;
        for (int c = 0; c < 800; c++) begin
            r  = int'($urandom_range(0, 9));
            v  = coin_tab[$urandom_range(0, 8)];
            it = int'($urandom_range(0, 3));
            coin_valid   = (r <= 4);
            sel_valid    = (r == 5 || r == 6);
            cancel       = (r == 7);
            coin_value   = 8'(v);
            sel_item     = 2'(it);
            vend_ready   = ($urandom_range(0, 1) == 1);
            change_ready = ($urandom_range(0, 2) != 0);

            e_rej = 0; e_err = 0;
            if (m_vend) begin
                e_rej = coin_valid;
                if (vend_ready) begin m_vend = 0; m_refund = (m_credit > 0); end
            end else if (m_refund) begin
                e_rej = coin_valid;
                if (change_ready) begin
                    m_credit -= 5;
                    if (m_credit == 0) m_refund = 0;
                end
            end else if (cancel && m_credit > 0) begin
                m_refund = 1;
            end else if (sel_valid) begin
                if (m_credit > 0 && m_credit >= price_tab[it]) begin
                    m_credit -= price_tab[it]; m_item = it; m_vend = 1;
                end else begin
                    e_err = 1;
                end
            end else if (coin_valid) begin
                if (v != 0 && v % 5 == 0 && m_credit + v <= 200) m_credit += v;
                else e_rej = 1;
            end

            step();
            n_checks++;
            if (credit !== 8'(m_credit) || vend_valid !== m_vend || change_valid !== m_refund ||
                vend_item !== 2'(m_item) || coin_reject !== e_rej || sel_error !== e_err ||
                busy !== (m_vend | m_refund)) begin
                n_errors++;
                $display("FAIL random[%0d]: got cr=%0d vv=%0b vi=%0d cv=%0b rj=%0b se=%0b busy=%0b expected cr=%0d vv=%0b vi=%0d cv=%0b rj=%0b se=%0b busy=%0b",
                         c, credit, vend_valid, vend_item, change_valid, coin_reject, sel_error, busy,
                         m_credit, m_vend, m_item, m_refund, e_rej, e_err, m_vend | m_refund);
            end
        end
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        vend_ready = 1'b0; change_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_overpay();
        test_short_pay();
        test_rejects();
        test_backpressure();
        test_reset_mid_change();
        test_coincident();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
